pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
// - Owns the fetch PC and drives the instruction-memory fetch handshake for the single-cycle/pipelined MIPS core.
// - Arbitrates next-PC sources: exception, jump-register, taken branch, jump, sequential +4.
// - Buffers one pending redirect while a fetch is outstanding or the front end is stalled.
// - Sits between the control unit / branch compare logic and the instruction memory; replaces the bare PC register as the PC source.
// PARAMETERS
// - RESET_VECTOR  32'h0000_0000  PC loaded on reset
// - EXC_VECTOR    32'h8000_0180  PC loaded on exception redirect
// PORTS
// - clk            in   1   clock; all state updates on posedge clk
// - reset_n        in   1   asynchronous active-low reset
// - stall          in   1   hazard stall from pipeline; holds PC, no new fetch
// - exc            in   1   exception request (priority 1, target EXC_VECTOR)
// - jr             in   1   jump-register (priority 2), jr_target 32 in
// - branch_taken   in   1   taken branch (priority 3), branch_target 32 in
// - jump           in   1   J/JAL (priority 4), jump_target 32 in
// - jr_target/branch_target/jump_target  in  32  redirect addresses
// - imem_ack       in   1   instruction memory accepted current imem_addr
// - imem_req       out  1   fetch request
// - imem_addr      out  32  fetch address (= pc)
// - pc             out  32  current fetch PC
// - pc_plus4       out  32  pc + 4 (combinational, for JAL link / branch base)
// - epc            out  32  pc captured when exc accepted
// - redirect_pend  out  1   a buffered redirect is waiting
// - addr_err       out  1   one-cycle pulse: accepted redirect target[1:0] != 0
// BEHAVIOUR
// - Reset (async, any state): state=S_RESET, pc=RESET_VECTOR, epc=0, pend_valid=0, pend_addr=0, imem_req=0, addr_err=0.
// - FSM states: S_RESET, S_FETCH, S_HOLD.
// - S_RESET: imem_req=0; next cycle -> S_FETCH unconditionally (first fetch one cycle after reset release).
// - S_FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack.
//   - imem_ack=1: pc <= pend_addr if pend_valid, else this-cycle winner if any redirect, else pc+4; pend_valid <= 0.
//     Then stall ? S_HOLD : S_FETCH (back-to-back fetch, 1 fetch per cycle when ack tied high).
//   - imem_ack=0: pc unchanged; any redirect is captured into pend (see buffering); stay S_FETCH (stall ignored until ack).
// - S_HOLD: imem_req=0, pc held; redirects captured into pend; stall=0 -> S_FETCH with pc <= pend_addr if pend_valid, pend_valid <= 0.
// - Arbitration: fixed priority exc > jr > branch_taken > jump; lower sources same cycle dropped.
// - Buffering: one entry. Incoming winner overwrites pend only if its priority >= stored priority; exc always overwrites.
// - Same-cycle ack + redirect with pend_valid: pending entry used unless new winner has strictly higher priority.
// - exc accepted (captured or applied): epc <= pc (address of in-flight fetch); epc updated only for exc.
// - Alignment: target[1:0] forced to 2'b00 on capture; addr_err pulses for exactly 1 cycle.
// - pc arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0, no flag.
// - Reset asserted mid-fetch: imem_req drops immediately (async), pending redirect discarded.
// STRUCTURE
// - Shared package (mips_pkg): state encoding S_RESET/S_FETCH/S_HOLD, redirect priority codes, RESET_VECTOR/EXC_VECTOR defaults.
// - Sub-module: pc_redirect_arb (combinational priority select -> {valid, prio[2:0], target}); FSM, pc, pend, epc regs in top.
// TESTING
// - Reset release, imem_ack=1, no redirects -> imem_req low 1 cycle, then imem_addr 0,4,8,12 on consecutive cycles.
// - pc=0x40, branch_taken=1 target 0x100, ack=1 -> next imem_addr 0x100; ack=0 that cycle -> addr stays 0x40, redirect_pend=1, then 0x100 after ack.
// - jump(0x200) then jr(0x300) while ack=0 -> pend=0x300; later jump(0x400) ignored; after ack pc=0x300.
// - pc=0x44 stalled in S_HOLD, exc=1 -> epc=0x44, stall release -> imem_addr=0x8000_0180.
// - jr_target=0x1003 -> fetch 0x1000, addr_err high exactly 1 cycle; pc=0xFFFF_FFFC + ack -> pc=0.
// - reset_n low mid-fetch with pend_valid -> imem_req=0 immediately, after release fetch restarts at RESET_VECTOR, redirect_pend=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch-sequencer states,
// redirect priority codes and default reset/exception vectors.
package mips_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } seq_state_t;

    // Larger code means higher priority, so a plain magnitude compare decides overwrites.
    typedef enum logic [2:0] {
        PRIO_NONE   = 3'd0,
        PRIO_JUMP   = 3'd1,
        PRIO_BRANCH = 3'd2,
        PRIO_JR     = 3'd3,
        PRIO_EXC    = 3'd4
    } redirect_prio_t;

    typedef struct packed {
        logic           valid;
        redirect_prio_t prio;
        logic [31:0]    target;
    } redirect_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational fixed-priority select of this cycle's next-PC redirect:
// exception, then jump-register, then taken branch, then jump.
module pc_redirect_arb
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        i_exc,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    output redirect_t   o_redirect
);

    always_comb begin
        o_redirect.valid  = 1'b1;
        o_redirect.prio   = PRIO_NONE;
        o_redirect.target = '0;
        if (i_exc) begin
            o_redirect.prio   = PRIO_EXC;
            o_redirect.target = EXC_VECTOR;
        end else if (i_jr) begin
            o_redirect.prio   = PRIO_JR;
            o_redirect.target = i_jr_target;
        end else if (i_branch_taken) begin
            o_redirect.prio   = PRIO_BRANCH;
            o_redirect.target = i_branch_target;
        end else if (i_jump) begin
            o_redirect.prio   = PRIO_JUMP;
            o_redirect.target = i_jump_target;
        end else begin
            o_redirect.valid  = 1'b0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: drives the instruction-memory request handshake and
// applies or buffers next-PC redirects while a fetch is outstanding or stalled.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stall,
    input  logic        i_exc,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_imem_ack,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_epc,
    output logic        o_redirect_pend,
    output logic        o_addr_err
);

    seq_state_t     r_state;
    logic [31:0]    r_pc;
    logic [31:0]    r_epc;
    logic           r_pend_valid;
    logic [31:0]    r_pend_addr;
    redirect_prio_t r_pend_prio;
    logic           r_imem_req;
    logic           r_addr_err;

    redirect_t      w_redirect;
    logic [31:0]    w_pc_plus4;
    logic [31:0]    w_new_target;
    logic           w_misaligned;
    logic           w_capture_ok;
    logic           w_override_ok;
    logic           w_capture;
    logic           w_apply_new;
    logic           w_accept;

    pc_redirect_arb #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .i_exc           (i_exc),
        .i_jr            (i_jr),
        .i_jr_target     (i_jr_target),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .o_redirect      (w_redirect)
    );

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_new_target = align_word(w_redirect.target);
    assign w_misaligned = |w_redirect.target[1:0];

    // Buffering replaces an equal-or-lower entry; at fetch completion the
    // buffered entry only loses to a strictly higher-priority newcomer.
    assign w_capture_ok  = w_redirect.valid &&
                           (!r_pend_valid || (w_redirect.prio >= r_pend_prio));
    assign w_override_ok = w_redirect.valid &&
                           (!r_pend_valid || (w_redirect.prio > r_pend_prio));

    always_comb begin
        w_capture   = 1'b0;
        w_apply_new = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (i_imem_ack) begin
                    w_apply_new = w_override_ok;
                end else begin
                    w_capture   = w_capture_ok;
                end
            end
            S_HOLD: begin
                if (i_stall) begin
                    w_capture   = w_capture_ok;
                end else begin
                    w_apply_new = w_capture_ok;
                end
            end
            default: begin
                w_capture   = 1'b0;
                w_apply_new = 1'b0;
            end
        endcase
    end

    assign w_accept = w_capture | w_apply_new;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_RESET;
            r_pc         <= RESET_VECTOR;
            r_epc        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_prio  <= PRIO_NONE;
            r_imem_req   <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_addr_err <= w_accept & w_misaligned;

            // EPC records the address of the fetch in flight when the exception lands.
            if (w_accept && (w_redirect.prio == PRIO_EXC)) begin
                r_epc <= r_pc;
            end

            if (w_capture) begin
                r_pend_valid <= 1'b1;
                r_pend_addr  <= w_new_target;
                r_pend_prio  <= w_redirect.prio;
            end

            case (r_state)
                S_RESET: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        r_pend_valid <= 1'b0;
                        if (w_apply_new) begin
                            r_pc <= w_new_target;
                        end else if (r_pend_valid) begin
                            r_pc <= r_pend_addr;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                        r_state    <= i_stall ? S_HOLD : S_FETCH;
                        r_imem_req <= !i_stall;
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        r_pend_valid <= 1'b0;
                        if (w_apply_new) begin
                            r_pc <= w_new_target;
                        end else if (r_pend_valid) begin
                            r_pc <= r_pend_addr;
                        end
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_RESET;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req      = r_imem_req;
    assign o_imem_addr     = r_pc;
    assign o_pc            = r_pc;
    assign o_pc_plus4      = w_pc_plus4;
    assign o_epc           = r_epc;
    assign o_redirect_pend = r_pend_valid;
    assign o_addr_err      = r_addr_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer; expectations come from a
// transaction-level model of fetch, redirect priority and single-entry buffering.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        resetN;
    logic        stall;
    logic        exc;
    logic        jr;
    logic [31:0] jrTarget;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] jumpTarget;
    logic        imemAck;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] epc;
    logic        redirectPend;
    logic        addrErr;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [31:0] addr;
        int          prio;
    } pend_t;

    pend_t       pendQ[$];
    bit          mBoot;
    bit          mFetching;
    logic [31:0] mPc;
    logic [31:0] mEpc;
    bit          mAddrErr;

    pc_sequencer #(
        .RESET_VECTOR (RESET_VEC),
        .EXC_VECTOR   (EXC_VEC)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (resetN),
        .i_stall         (stall),
        .i_exc           (exc),
        .i_jr            (jr),
        .i_jr_target     (jrTarget),
        .i_branch_taken  (branchTaken),
        .i_branch_target (branchTarget),
        .i_jump          (jump),
        .i_jump_target   (jumpTarget),
        .i_imem_ack      (imemAck),
        .o_imem_req      (imemReq),
        .o_imem_addr     (imemAddr),
        .o_pc            (pc),
        .o_pc_plus4      (pcPlus4),
        .o_epc           (epc),
        .o_redirect_pend (redirectPend),
        .o_addr_err      (addrErr)
    );

    always #5 clk = ~clk;

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        assert (got === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        pendQ.delete();
        mBoot     = 1'b1;
        mFetching = 1'b0;
        mPc       = RESET_VEC;
        mEpc      = 32'h0;
        mAddrErr  = 1'b0;
    endtask

    task automatic noteAccept(input int prio, input logic [31:0] tgt);
        mAddrErr = (tgt[1:0] != 2'b00);
        if (prio == 4) mEpc = mPc;
    endtask

    // One clock of the fetch/redirect rules, evaluated on the inputs now being driven.
    task automatic modelStep();
        int          prio;
        logic [31:0] tgt;
        bit          hasPend;
        bit          take;
        pend_t       entry;
        prio    = exc ? 4 : jr ? 3 : branchTaken ? 2 : jump ? 1 : 0;
        tgt     = exc ? EXC_VEC : jr ? jrTarget : branchTaken ? branchTarget : jumpTarget;
        hasPend = (pendQ.size() != 0);
        mAddrErr = 1'b0;
        if (mBoot) begin
            mBoot     = 1'b0;
            mFetching = 1'b1;
        end else if (mFetching && imemAck) begin
            take = (prio != 0) && (!hasPend || prio > pendQ[0].prio);
            if (take) noteAccept(prio, tgt);
            if (take)         mPc = tgt & 32'hFFFF_FFFC;
            else if (hasPend) mPc = pendQ[0].addr;
            else              mPc = mPc + 32'd4;
            pendQ.delete();
            mFetching = !stall;
        end else begin
            take = (prio != 0) && (!hasPend || prio >= pendQ[0].prio);
            if (take) noteAccept(prio, tgt);
            if (mFetching || stall) begin
                if (take) begin
                    entry.addr = tgt & 32'hFFFF_FFFC;
                    entry.prio = prio;
                    pendQ.delete();
                    pendQ.push_back(entry);
                end
            end else begin
                if (take)         mPc = tgt & 32'hFFFF_FFFC;
                else if (hasPend) mPc = pendQ[0].addr;
                pendQ.delete();
                mFetching = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        expectEq({tag, ".req"},     {31'b0, imemReq},      {31'b0, mFetching});
        expectEq({tag, ".addr"},    imemAddr,              mPc);
        expectEq({tag, ".pc"},      pc,                    mPc);
        expectEq({tag, ".pcPlus4"}, pcPlus4,               mPc + 32'd4);
        expectEq({tag, ".epc"},     epc,                   mEpc);
        expectEq({tag, ".pend"},    {31'b0, redirectPend}, {31'b0, pendQ.size() != 0});
        expectEq({tag, ".addrErr"}, {31'b0, addrErr},      {31'b0, mAddrErr});
    endtask

    // Called just after a falling edge; drives one cycle and checks at the next falling edge.
    task automatic applyStimulus(input bit s, input bit e, input bit j, input bit b, input bit jp,
                                 input bit a, input logic [31:0] jt, input logic [31:0] bt,
                                 input logic [31:0] jpt, input string tag);
        stall        = s;
        exc          = e;
        jr           = j;
        branchTaken  = b;
        jump         = jp;
        imemAck      = a;
        jrTarget     = jt;
        branchTarget = bt;
        jumpTarget   = jpt;
        modelStep();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic resetMidCycle(input string tag);
        stall = 1'b0; exc = 1'b0; jr = 1'b0; branchTaken = 1'b0; jump = 1'b0; imemAck = 1'b0;
        #3 resetN = 1'b0;
        #1;
        expectEq({tag, ".reqAsync"},  {31'b0, imemReq},      32'd0);
        expectEq({tag, ".pendAsync"}, {31'b0, redirectPend}, 32'd0);
        modelReset();
        @(negedge clk);
        checkOutput(tag);
        resetN = 1'b1;
    endtask

    function automatic logic [31:0] randTarget();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        resetN = 1'b0;
        stall = 1'b0; exc = 1'b0; jr = 1'b0; branchTaken = 1'b0; jump = 1'b0; imemAck = 1'b0;
        jrTarget = '0; branchTarget = '0; jumpTarget = '0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset");
        expectEq("reset.reqConst", {31'b0, imemReq}, 32'd0);
        expectEq("reset.pcConst",  pc,               RESET_VEC);
        expectEq("reset.epcConst", epc,              32'h0);
        resetN = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, "seq");
            expectEq("seq.addrConst", imemAddr, 32'(i * 4));
        end

        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 32'h40, "toPc40");
        applyStimulus(0, 0, 0, 1, 0, 1, 0, 32'h100, 0, "brAck");
        expectEq("brAck.addrConst", imemAddr, 32'h100);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 32'h40, "toPc40b");
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h100, 0, "brNoAck");
        expectEq("brNoAck.addrConst", imemAddr, 32'h40);
        expectEq("brNoAck.pendConst", {31'b0, redirectPend}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, "brLateAck");
        expectEq("brLateAck.addrConst", imemAddr, 32'h100);

        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'h200, "pendJump");
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h300, 0, 0, "pendJr");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'h400, "pendJumpLow");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, "pendAck");
        expectEq("pendAck.addrConst", imemAddr, 32'h300);

        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 32'h40, "toPc40c");
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, "enterHold");
        expectEq("enterHold.reqConst", {31'b0, imemReq}, 32'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, "excInHold");
        expectEq("excInHold.epcConst", epc, 32'h44);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "holdRelease");
        expectEq("holdRelease.addrConst", imemAddr, EXC_VEC);

        applyStimulus(0, 0, 1, 0, 0, 1, 32'h1003, 0, 0, "misaligned");
        expectEq("misaligned.addrConst", imemAddr, 32'h1000);
        expectEq("misaligned.errConst", {31'b0, addrErr}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "errPulseEnd");
        expectEq("errPulseEnd.errConst", {31'b0, addrErr}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 32'hFFFF_FFFC, "toTop");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, "wrap");
        expectEq("wrap.pcConst", pc, 32'h0);

        applyStimulus(0, 0, 1, 0, 0, 0, 32'h500, 0, 0, "pendBeforeReset");
        resetMidCycle("midReset");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, "restart");
        expectEq("restart.addrConst", imemAddr, RESET_VEC);
        expectEq("restart.pendConst", {31'b0, redirectPend}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            bit          s, e, j, b, jp, a;
            logic [31:0] t1, t2, t3;
            s  = ($urandom_range(0, 3) == 0);
            e  = ($urandom_range(0, 15) == 0);
            j  = ($urandom_range(0, 7) == 0);
            b  = ($urandom_range(0, 6) == 0);
            jp = ($urandom_range(0, 6) == 0);
            a  = ($urandom_range(0, 9) < 6);
            t1 = randTarget();
            t2 = randTarget();
            t3 = randTarget();
            applyStimulus(s, e, j, b, jp, a, t1, t2, t3, "rand");
            if ((i % 200) == 199) resetMidCycle("randReset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
